// File: rtl/single_cycle_mips16.sv
// single_cycle_mips16: 16-bit single-cycle MIPS-style CPU with its own instruction
// memory, 16x16 register file and 16-bit data memory.
// Optional build macro HALT_EN: opcode 111111 becomes HALT and a 'halted' output appears.

// Instruction store; the load port lets an external loader fill it (tied idle in the CPU).
module InstMem #(
   parameter int DEPTH = 1024
) (
   input  logic        clock,
   input  logic        loadEn,
   input  logic [9:0]  loadAddr,
   input  logic [31:0] loadData,
   input  logic [9:0]  addr,
   output logic [31:0] data
);
   logic [31:0] memory [0:DEPTH-1];

   // Optional program load, one word per clock
   always_ff @(posedge clock) begin
      if (loadEn)
         memory[loadAddr] <= loadData;
   end

   assign data = memory[addr];
endmodule

// Register file with two combinational reads and one clocked write; r0 is hardwired to zero.
module RegFile (
   input  logic        clock,
   input  logic        reset,
   input  logic        we,
   input  logic [3:0]  wAddr,
   input  logic [15:0] wData,
   input  logic [3:0]  rAddr1,
   input  logic [3:0]  rAddr2,
   output logic [15:0] rData1,
   output logic [15:0] rData2
);
   logic [15:0] registers [0:15];

   // Clear everything on reset, otherwise write back, never into r0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            registers[i] <= '0;
      end else if (we && (wAddr != 4'd0)) begin
         registers[wAddr] <= wData;
      end
   end

   assign rData1 = (rAddr1 == 4'd0) ? 16'h0000 : registers[rAddr1];
   assign rData2 = (rAddr2 == 4'd0) ? 16'h0000 : registers[rAddr2];
endmodule

// Data memory: combinational read, clocked write, contents survive reset.
module DataMem #(
   parameter int DEPTH = 1024
) (
   input  logic        clock,
   input  logic        we,
   input  logic [9:0]  addr,
   input  logic [15:0] wData,
   output logic [15:0] rData
);
   logic [15:0] memory [0:DEPTH-1];

   // Store word on the rising edge
   always_ff @(posedge clock) begin
      if (we)
         memory[addr] <= wData;
   end

   assign rData = memory[addr];
endmodule

module single_cycle_mips16 #(
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic        clock,
   input  logic        reset,
   output logic [9:0]  pc_out,
   output logic [31:0] instr_out
`ifdef HALT_EN
   ,
   output logic        halted
`endif
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000001;
   localparam logic [5:0] OP_ANDI  = 6'b000010;
   localparam logic [5:0] OP_ORI   = 6'b000011;
   localparam logic [5:0] OP_SLTI  = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b000101;
   localparam logic [5:0] OP_SW    = 6'b000110;
   localparam logic [5:0] OP_BEQ   = 6'b000111;
   localparam logic [5:0] OP_BNE   = 6'b001000;
   localparam logic [5:0] OP_LI    = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b001010;
   localparam logic [5:0] OP_JAL   = 6'b001011;
`ifdef HALT_EN
   localparam logic [5:0] OP_HALT  = 6'b111111;
`endif

   logic [9:0]  pc, pcPlus1, nextPc, branch_addr;
   logic [31:0] instruction;
   logic [5:0]  opcode;
   logic [3:0]  funct;
   logic [15:0] imm;
   logic        regDst, regWrite, memWrite, memToReg, branch, branchNot;
   logic        jumpAndLink, jumpReg, jump, aluSrc, loadImm, isHalt;
   logic [2:0]  aluOp;
   logic [3:0]  read_reg1, read_reg2, write_reg;
   logic [15:0] read_data1, read_data2, write_back, memData;
   logic [15:0] alu_a, alu_b, alu_res;
   logic        alu_zero;

   InstMem #(.DEPTH(IMEM_DEPTH)) inst_mem (
      .clock(clock), .loadEn(1'b0), .loadAddr(10'd0), .loadData(32'd0),
      .addr(pc), .data(instruction)
   );

   assign opcode    = instruction[31:26];
   assign read_reg1 = instruction[25:22];
   assign read_reg2 = instruction[21:18];
   assign funct     = instruction[3:0];
   assign imm       = instruction[15:0];

   // Decode opcode/funct into datapath controls; anything unrecognised stays a NOP
   always_comb begin
      regDst = 1'b0; regWrite = 1'b0; memWrite = 1'b0; memToReg = 1'b0;
      branch = 1'b0; branchNot = 1'b0; jumpAndLink = 1'b0; jumpReg = 1'b0;
      jump = 1'b0; aluSrc = 1'b0; loadImm = 1'b0; isHalt = 1'b0;
      aluOp = 3'b010;
      case (opcode)
         OP_RTYPE: begin
            regDst = 1'b1;
            case (funct)
               4'b0000: begin aluOp = 3'b000; regWrite = 1'b1; end
               4'b0001: begin aluOp = 3'b001; regWrite = 1'b1; end
               4'b0010: begin aluOp = 3'b010; regWrite = 1'b1; end
               4'b0011: begin aluOp = 3'b011; regWrite = 1'b1; end
               4'b0100: begin aluOp = 3'b100; regWrite = 1'b1; end
               4'b0101: begin aluOp = 3'b101; regWrite = 1'b1; end
               4'b1000: jumpReg = 1'b1;
               default: ;
            endcase
         end
         OP_ADDI: begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = 3'b010; end
         OP_ANDI: begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = 3'b000; end
         OP_ORI:  begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = 3'b001; end
         OP_SLTI: begin regWrite = 1'b1; aluSrc = 1'b1; aluOp = 3'b100; end
         OP_LW:   begin regWrite = 1'b1; aluSrc = 1'b1; memToReg = 1'b1; end
         OP_SW:   begin memWrite = 1'b1; aluSrc = 1'b1; end
         OP_BEQ:  begin branch = 1'b1; aluOp = 3'b011; end
         OP_BNE:  begin branchNot = 1'b1; aluOp = 3'b011; end
         OP_LI:   begin regWrite = 1'b1; loadImm = 1'b1; end
         OP_J:    jump = 1'b1;
         OP_JAL:  begin jump = 1'b1; jumpAndLink = 1'b1; regWrite = 1'b1; end
`ifdef HALT_EN
         OP_HALT: isHalt = 1'b1;
`endif
         default: ;
      endcase
   end

   RegFile regs (
      .clock(clock), .reset(reset), .we(regWrite), .wAddr(write_reg), .wData(write_back),
      .rAddr1(read_reg1), .rAddr2(read_reg2), .rData1(read_data1), .rData2(read_data2)
   );

   // With a 16-bit datapath and 16-bit immediate, sign and zero extension are identical
   assign alu_a = read_data1;
   assign alu_b = aluSrc ? imm : read_data2;

   // ALU operation select
   always_comb begin
      alu_res = 16'h0000;
      case (aluOp)
         3'b000:  alu_res = alu_a & alu_b;
         3'b001:  alu_res = alu_a | alu_b;
         3'b010:  alu_res = alu_a + alu_b;
         3'b011:  alu_res = alu_a - alu_b;
         3'b100:  alu_res = {15'd0, ($signed(alu_a) < $signed(alu_b))};
         3'b101:  alu_res = alu_a ^ alu_b;
         default: alu_res = 16'h0000;
      endcase
   end
   assign alu_zero = (alu_res == 16'h0000);

   // A store still in flight when reset arrives must not land in memory
   DataMem #(.DEPTH(DMEM_DEPTH)) data_mem (
      .clock(clock), .we(memWrite & ~reset), .addr(alu_res[9:0]),
      .wData(read_data2), .rData(memData)
   );

   assign write_reg  = jumpAndLink ? 4'd15 : (regDst ? instruction[17:14] : read_reg2);
   assign write_back = jumpAndLink ? {6'd0, pcPlus1} :
                       loadImm     ? imm :
                       memToReg    ? memData : alu_res;

   assign pcPlus1     = pc + 10'd1;
   assign branch_addr = pcPlus1 + imm[9:0];

   // Next-PC selection: halt, register jump, absolute jump, branch, sequential
   always_comb begin
      nextPc = pcPlus1;
      if (isHalt)
         nextPc = pc;
      else if (jumpReg)
         nextPc = read_data1[9:0];
      else if (jump)
         nextPc = instruction[9:0];
      else if ((branch && alu_zero) || (branchNot && !alu_zero))
         nextPc = branch_addr;
   end

   // Program counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pc <= 10'd0;
      else
         pc <= nextPc;
   end

`ifdef HALT_EN
   // Sticky halt flag, cleared only by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         halted <= 1'b0;
      else if (isHalt)
         halted <= 1'b1;
   end
`endif

   assign pc_out    = pc;
   assign instr_out = instruction;
endmodule

// File: tb/tb_single_cycle_mips16.sv
// Directed testbench for single_cycle_mips16: programs are preloaded into
// inst_mem.memory and results are read back from regs.registers / data_mem.memory.
module tb_single_cycle_mips16;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pc_out;
   logic [31:0] instr_out;
`ifdef HALT_EN
   logic        halted;
`endif
   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP  = 32'hF800_0000;
   localparam logic [5:0] OP_ADDI = 6'b000001, OP_ANDI = 6'b000010, OP_ORI = 6'b000011;
   localparam logic [5:0] OP_SLTI = 6'b000100, OP_LW = 6'b000101, OP_SW = 6'b000110;
   localparam logic [5:0] OP_BEQ = 6'b000111, OP_BNE = 6'b001000, OP_LI = 6'b001001;
   localparam logic [5:0] OP_JAL = 6'b001011;

   single_cycle_mips16 dut (
      .clock(clock),
      .reset(reset),
      .pc_out(pc_out),
      .instr_out(instr_out)
`ifdef HALT_EN
      ,
      .halted(halted)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   function automatic logic [31:0] rtype(input logic [3:0] rs, input logic [3:0] rt,
                                         input logic [3:0] rd, input logic [3:0] fn);
      return {6'b000000, rs, rt, rd, 10'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [3:0] rs,
                                         input logic [3:0] rt, input logic [15:0] im);
      return {op, rs, rt, 2'b00, im};
   endfunction

   function automatic logic [31:0] li(input logic [3:0] rt, input logic [15:0] im);
      return {OP_LI, 4'd0, rt, 2'b00, im};
   endfunction

   // Hold the CPU in reset and fill instruction memory with NOPs
   task automatic applyStimulus();
      reset = 1'b1;
      for (int i = 0; i < 1024; i++)
         dut.inst_mem.memory[i] = NOP;
   endtask

   task automatic releaseReset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic runCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'h1111);
      @(negedge clock);
      checks++;
      if (pc_out !== 10'd0) begin
         errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc_out);
      end
      checks++;
      if (instr_out !== 32'h2404_1111) begin
         errors++; $display("[TB] FAIL reset_instr: got %h expected 24041111", instr_out);
      end
      for (int r = 0; r < 16; r++) begin
         checks++;
         if (dut.regs.registers[r] !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 0000", r, dut.regs.registers[r]);
         end
      end
      releaseReset();
      runCycles(1);
      checks++;
      if (dut.regs.registers[1] !== 16'h1111 || pc_out !== 10'd1) begin
         errors++; $display("[TB] FAIL first_instr: r1=%h pc=%0d expected r1=1111 pc=1", dut.regs.registers[1], pc_out);
      end
   endtask

   task automatic test_bne_taken();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'd5);
      dut.inst_mem.memory[1] = li(4'd2, 16'd3);
      dut.inst_mem.memory[2] = itype(OP_BNE, 4'd1, 4'd2, 16'd2);
      dut.inst_mem.memory[3] = li(4'd3, 16'd9);
      dut.inst_mem.memory[4] = li(4'd4, 16'd9);
      dut.inst_mem.memory[5] = li(4'd5, 16'd1);
      releaseReset();
      runCycles(3);
      checks++;
      if (pc_out !== 10'd5) begin
         errors++; $display("[TB] FAIL bne_taken_pc: got %0d expected 5", pc_out);
      end
      runCycles(1);
      checks++;
      if (dut.regs.registers[3] !== 16'h0000 || dut.regs.registers[4] !== 16'h0000) begin
         errors++; $display("[TB] FAIL bne_skipped: r3=%h r4=%h expected 0000 0000", dut.regs.registers[3], dut.regs.registers[4]);
      end
      checks++;
      if (dut.regs.registers[5] !== 16'h0001) begin
         errors++; $display("[TB] FAIL bne_target_exec: r5=%h expected 0001", dut.regs.registers[5]);
      end
   endtask

   task automatic test_bne_not_taken();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'd7);
      dut.inst_mem.memory[1] = li(4'd2, 16'd7);
      dut.inst_mem.memory[2] = itype(OP_BNE, 4'd1, 4'd2, 16'd2);
      releaseReset();
      runCycles(2);
      checks++;
      if (dut.alu_zero !== 1'b1) begin
         errors++; $display("[TB] FAIL bne_nt_zero: alu_zero=%b expected 1", dut.alu_zero);
      end
      runCycles(1);
      checks++;
      if (pc_out !== 10'd3) begin
         errors++; $display("[TB] FAIL bne_nt_pc: got %0d expected 3", pc_out);
      end
   endtask

   task automatic test_beq();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'd4);
      dut.inst_mem.memory[1] = li(4'd2, 16'd4);
      dut.inst_mem.memory[2] = itype(OP_BEQ, 4'd1, 4'd2, 16'd3);
      releaseReset();
      runCycles(3);
      checks++;
      if (pc_out !== 10'd6) begin
         errors++; $display("[TB] FAIL beq_taken_pc: got %0d expected 6", pc_out);
      end
   endtask

   task automatic test_memory();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'h1234);
      dut.inst_mem.memory[1] = li(4'd2, 16'd4);
      dut.inst_mem.memory[2] = itype(OP_SW, 4'd2, 4'd1, 16'd0);
      dut.inst_mem.memory[3] = itype(OP_LW, 4'd2, 4'd3, 16'd0);
      dut.inst_mem.memory[4] = itype(OP_SW, 4'd2, 4'd2, 16'hFFFF);
      releaseReset();
      runCycles(5);
      checks++;
      if (dut.data_mem.memory[4] !== 16'h1234) begin
         errors++; $display("[TB] FAIL sw_data: mem[4]=%h expected 1234", dut.data_mem.memory[4]);
      end
      checks++;
      if (dut.regs.registers[3] !== 16'h1234) begin
         errors++; $display("[TB] FAIL lw_data: r3=%h expected 1234", dut.regs.registers[3]);
      end
      checks++;
      if (dut.data_mem.memory[3] !== 16'h0004) begin
         errors++; $display("[TB] FAIL sw_neg_offset: mem[3]=%h expected 0004", dut.data_mem.memory[3]);
      end
   endtask

   task automatic test_immediate();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd2, 16'd4);
      dut.inst_mem.memory[1] = itype(OP_ADDI, 4'd2, 4'd5, 16'hFFFA);
      dut.inst_mem.memory[2] = itype(OP_SLTI, 4'd5, 4'd8, 16'd1);
      dut.inst_mem.memory[3] = itype(OP_ORI, 4'd0, 4'd7, 16'h00F0);
      dut.inst_mem.memory[4] = itype(OP_ANDI, 4'd5, 4'd9, 16'h00FF);
      dut.inst_mem.memory[5] = itype(OP_SLTI, 4'd2, 4'd10, 16'hFFFF);
      releaseReset();
      runCycles(6);
      checks++;
      if (dut.regs.registers[5] !== 16'hFFFE) begin
         errors++; $display("[TB] FAIL addi_neg: r5=%h expected fffe", dut.regs.registers[5]);
      end
      checks++;
      if (dut.regs.registers[8] !== 16'h0001) begin
         errors++; $display("[TB] FAIL slti_signed: r8=%h expected 0001", dut.regs.registers[8]);
      end
      checks++;
      if (dut.regs.registers[7] !== 16'h00F0 || dut.regs.registers[9] !== 16'h00FE) begin
         errors++; $display("[TB] FAIL ori_andi: r7=%h r9=%h expected 00f0 00fe", dut.regs.registers[7], dut.regs.registers[9]);
      end
      checks++;
      if (dut.regs.registers[10] !== 16'h0000) begin
         errors++; $display("[TB] FAIL slti_false: r10=%h expected 0000", dut.regs.registers[10]);
      end
   endtask

   task automatic test_call_return();
      applyStimulus();
      dut.inst_mem.memory[0]  = li(4'd1, 16'd1);
      dut.inst_mem.memory[3]  = {OP_JAL, 16'd0, 10'd10};
      dut.inst_mem.memory[4]  = li(4'd2, 16'h0055);
      dut.inst_mem.memory[10] = rtype(4'd15, 4'd0, 4'd0, 4'b1000);
      releaseReset();
      runCycles(4);
      checks++;
      if (pc_out !== 10'd10) begin
         errors++; $display("[TB] FAIL jal_pc: got %0d expected 10", pc_out);
      end
      checks++;
      if (dut.regs.registers[15] !== 16'h0004) begin
         errors++; $display("[TB] FAIL jal_link: r15=%h expected 0004", dut.regs.registers[15]);
      end
      runCycles(1);
      checks++;
      if (pc_out !== 10'd4) begin
         errors++; $display("[TB] FAIL jr_pc: got %0d expected 4", pc_out);
      end
      runCycles(1);
      checks++;
      if (dut.regs.registers[2] !== 16'h0055) begin
         errors++; $display("[TB] FAIL after_return: r2=%h expected 0055", dut.regs.registers[2]);
      end
   endtask

   task automatic test_alu_r0();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'd3);
      dut.inst_mem.memory[1] = li(4'd2, 16'd5);
      dut.inst_mem.memory[2] = rtype(4'd1, 4'd1, 4'd0, 4'b0010);
      dut.inst_mem.memory[3] = rtype(4'd1, 4'd2, 4'd3, 4'b0011);
      dut.inst_mem.memory[4] = rtype(4'd1, 4'd2, 4'd4, 4'b0100);
      dut.inst_mem.memory[5] = rtype(4'd1, 4'd2, 4'd5, 4'b0101);
      dut.inst_mem.memory[6] = rtype(4'd1, 4'd2, 4'd6, 4'b0001);
      dut.inst_mem.memory[7] = rtype(4'd1, 4'd2, 4'd7, 4'b0000);
      dut.inst_mem.memory[8] = rtype(4'd3, 4'd1, 4'd8, 4'b0100);
      dut.inst_mem.memory[9] = rtype(4'd1, 4'd3, 4'd9, 4'b0100);
      releaseReset();
      runCycles(10);
      checks++;
      if (dut.regs.registers[0] !== 16'h0000) begin
         errors++; $display("[TB] FAIL r0_write: r0=%h expected 0000", dut.regs.registers[0]);
      end
      checks++;
      if (dut.regs.registers[3] !== 16'hFFFE) begin
         errors++; $display("[TB] FAIL sub_wrap: r3=%h expected fffe", dut.regs.registers[3]);
      end
      checks++;
      if (dut.regs.registers[4] !== 16'h0001) begin
         errors++; $display("[TB] FAIL slt: r4=%h expected 0001", dut.regs.registers[4]);
      end
      checks++;
      if (dut.regs.registers[5] !== 16'h0006 || dut.regs.registers[6] !== 16'h0007 || dut.regs.registers[7] !== 16'h0001) begin
         errors++; $display("[TB] FAIL logic_ops: xor=%h or=%h and=%h expected 0006 0007 0001",
                            dut.regs.registers[5], dut.regs.registers[6], dut.regs.registers[7]);
      end
      checks++;
      if (dut.regs.registers[8] !== 16'h0001 || dut.regs.registers[9] !== 16'h0000) begin
         errors++; $display("[TB] FAIL slt_signed: r8=%h r9=%h expected 0001 0000", dut.regs.registers[8], dut.regs.registers[9]);
      end
   endtask

   task automatic test_unknown_ops();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'd1);
      dut.inst_mem.memory[1] = rtype(4'd1, 4'd1, 4'd3, 4'b0110);
      dut.inst_mem.memory[2] = {6'b111111, 4'd1, 4'd3, 18'd7};
      dut.inst_mem.memory[3] = li(4'd2, 16'd2);
      releaseReset();
      runCycles(4);
      checks++;
      if (dut.regs.registers[3] !== 16'h0000) begin
         errors++; $display("[TB] FAIL unknown_nowrite: r3=%h expected 0000", dut.regs.registers[3]);
      end
`ifdef HALT_EN
      checks++;
      if (pc_out !== 10'd2 || halted !== 1'b1 || dut.regs.registers[2] !== 16'h0000) begin
         errors++; $display("[TB] FAIL halt_hold: pc=%0d halted=%b r2=%h expected 2 1 0000", pc_out, halted, dut.regs.registers[2]);
      end
`else
      checks++;
      if (pc_out !== 10'd4 || dut.regs.registers[2] !== 16'h0002) begin
         errors++; $display("[TB] FAIL op3f_nop: pc=%0d r2=%h expected 4 0002", pc_out, dut.regs.registers[2]);
      end
`endif
   endtask

   task automatic test_reset_midrun();
      applyStimulus();
      dut.inst_mem.memory[0] = li(4'd1, 16'h00AA);
      dut.inst_mem.memory[1] = li(4'd2, 16'd8);
      dut.inst_mem.memory[2] = itype(OP_SW, 4'd2, 4'd1, 16'd0);
      dut.inst_mem.memory[3] = li(4'd3, 16'd1);
      dut.inst_mem.memory[4] = li(4'd4, 16'd2);
      dut.inst_mem.memory[5] = li(4'd5, 16'd3);
      dut.inst_mem.memory[6] = li(4'd6, 16'd4);
      releaseReset();
      runCycles(5);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pc_out !== 10'd0) begin
         errors++; $display("[TB] FAIL midrun_pc: got %0d expected 0", pc_out);
      end
      for (int r = 1; r < 7; r++) begin
         checks++;
         if (dut.regs.registers[r] !== 16'h0000) begin
            errors++; $display("[TB] FAIL midrun_reg%0d: got %h expected 0000", r, dut.regs.registers[r]);
         end
      end
      checks++;
      if (dut.data_mem.memory[8] !== 16'h00AA) begin
         errors++; $display("[TB] FAIL midrun_dmem: mem[8]=%h expected 00aa", dut.data_mem.memory[8]);
      end
      releaseReset();
      runCycles(1);
      checks++;
      if (pc_out !== 10'd1 || dut.regs.registers[1] !== 16'h00AA) begin
         errors++; $display("[TB] FAIL restart: pc=%0d r1=%h expected 1 00aa", pc_out, dut.regs.registers[1]);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_bne_taken();
      test_bne_not_taken();
      test_beq();
      test_memory();
      test_immediate();
      test_call_return();
      test_alu_r0();
      test_unknown_ops();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/single_cycle_mips16.md
Name: single_cycle_mips16

Overview:
- 16-bit-datapath, single-cycle MIPS-style processor; every instruction completes in one clock.
- Contains a 32-bit-word instruction memory, a 16x16 register file and a 16-bit data memory.
- Top-level CPU of the teaching SoC. Benches preload memory arrays hierarchically and dump registers/data memory after a run.

Parameters:
- IMEM_DEPTH, 1024, instruction words, addressed by 10-bit PC.
- DMEM_DEPTH, 1024, 16-bit data words, addressed by alu_res[9:0].

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- pc_out  output  10  current PC (word address).
- instr_out  output  32  instruction currently being executed.

Behaviour:
- Internal hierarchy names are fixed: inst_mem.memory, regs.registers, data_mem.memory; these are the preload/dump points.
- Internal signal names are fixed: pc, instruction, opcode, regDst, regWrite, memWrite, memToReg, branch, branchNot, jumpAndLink, jumpReg, jump, aluSrc, loadImm, alu_a, alu_b, alu_res, alu_zero, aluOp[2:0], read_reg1, read_reg2, write_reg, read_data1, read_data2, write_back, branch_addr.
- Instruction fields:
  - opcode [31:26], rs [25:22], rt [21:18], rd [17:14].
  - funct [3:0] (R-type), imm [15:0] (I-type), target [9:0] (J-type).
- Opcodes:
  - 000000 R-type.
  - 000001 addi, 000010 andi, 000011 ori, 000100 slti.
  - 000101 lw, 000110 sw.
  - 000111 beq, 001000 bne.
  - 001001 li (rt <= imm).
  - 001010 j, 001011 jal.
  - Any other opcode executes as a NOP (PC+1, no writes).
- R-type funct codes: 0000 and, 0001 or, 0010 add, 0011 sub, 0100 slt (signed), 0101 xor, 1000 jr; other funct values are NOPs.
- aluOp encoding: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 xor.
- alu_zero = (alu_res == 0).
- Immediates:
  - sign-extended for addi, slti, lw, sw.
  - zero-extended for andi, ori.
  - li uses the raw 16 bits.
- Register destination and write-back:
  - R-type writes rd; I-type writes rt; jal writes r15 with pc+1 (zero-extended).
  - Writes to r0 are discarded; r0 always reads 0.
- Register file timing: two combinational read ports, one write port written on the rising edge.
- Data memory: lw reads combinationally; sw writes read_data2 to data_mem[alu_res[9:0]] on the rising edge.
- Next PC (all wrap mod 1024):
  - default pc+1.
  - branch_addr = pc+1+imm[9:0].
  - beq taken when alu_zero=1; bne taken when alu_zero=0 (branch compares via sub of rs and rt).
  - j and jal load target.
  - jr loads read_data1[9:0].
- Reset (asynchronous):
  - pc=0; all 16 registers=0.
  - Data and instruction memory are not cleared.
  - Reset asserted mid-run aborts the current instruction with no write; execution restarts at address 0 on the first rising edge after release.
- Arithmetic is 16-bit wrap-around, with no overflow trap.
- Outputs after reset: pc_out=0, instr_out=inst_mem[0].

Optional Feature:
- Macro HALT_EN.
- When defined:
  - opcode 111111 is HALT: PC holds and no register or memory writes occur until reset.
  - Output port halted (1 bit) is added; it is set on executing HALT and cleared by reset.
- When undefined: 111111 is a NOP and the port does not exist.

Test Plan:
- bne taken: li r1,5; li r2,3; bne r1,r2,+2 at PC 2 -> next PC 5; instructions at 3 and 4 are skipped (their target registers stay 0).
- bne not taken: li r1,7; li r2,7; bne r1,r2,+2 -> PC 3; alu_zero=1.
- Memory: li r1,0x1234; li r2,4; sw r1,0(r2); lw r3,0(r2) -> data_mem[4]=0x1234, r3=0x1234.
- Call/return: jal 10 at PC 3 -> r15=4, PC=10; jr r15 at 10 -> PC 4.
- ALU and r0:
  - add r0,r1,r1 -> r0 stays 0.
  - sub with r1=3, r2=5 -> 0xFFFE.
  - slt r4,r1,r2 -> 1.
- Reset mid-run: assert reset at cycle 5 -> pc=0 and all registers 0 immediately (asynchronously, before any clock edge); data_mem contents are preserved.
